cpu_dmem_window: RTL and testbench

- Data-memory stage directly downstream of the execute stage.
- Holds a small register-array window of data memory and reports the window bounds back to execute on DMEM_Base_Addr / DMEM_High_Addr.
- Services loads combinationally and stores on the clock edge.
- On an out-of-window access, writes back the window if it is dirty, then refills it from the external memory bus with a req/ack handshake.
- Execute stalls for the whole refill, because its own DMEM_no_hit stays set until the window covers DMEM_Addr.

---
 rtl/cpu_dmem_pkg.sv | 29 ++
 rtl/dmem_window_ram.sv | 36 +++
 rtl/cpu_dmem_window.sv | 230 +++++++++++++++++++++++
 tb/tb_cpu_dmem_window.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_dmem_pkg : shared types and constants for the data-memory window      |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
package cpu_dmem_pkg;

  localparam int DMEM_ADDR_W = 32;

  // Bounds that no address can satisfy (base > high)
  localparam logic [DMEM_ADDR_W-1:0] DMEM_BASE_INVALID = 32'hFFFF_FFFF;
  localparam logic [DMEM_ADDR_W-1:0] DMEM_HIGH_INVALID = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } dmem_state_e;

  function automatic logic [DMEM_ADDR_W-1:0] win_align(
    input logic [DMEM_ADDR_W-1:0] addr,
    input int                     depth_log2
  );
    return addr & ~((32'd1 << depth_log2) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_window_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_window_ram : register array, async read, sync write, zero on reset   |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module dmem_window_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/cpu_dmem_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_dmem_window : cached data-memory window with writeback/refill bursts  |
// | Optional perf counters with `define DMEM_PERF_CNT_EN.     Revision : 1.0  |
// +--------------------------------------------------------------------------+
module cpu_dmem_window
  import cpu_dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   DMEM_WE,
  input  logic [DMEM_ADDR_W-1:0] DMEM_Addr,
  input  logic [DATA_W-1:0]      DMEM_Data,
  input  logic                   DMEM_no_hit,
  output logic [DATA_W-1:0]      DMEM_DATA_WB_w,
  output logic [DMEM_ADDR_W-1:0] DMEM_Base_Addr,
  output logic [DMEM_ADDR_W-1:0] DMEM_High_Addr,
  output logic                   dmem_busy,
  output logic                   ext_req,
  output logic                   ext_we,
  output logic [DMEM_ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0]      ext_wdata,
  input  logic [DATA_W-1:0]      ext_rdata,
  input  logic                   ext_ack
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]            dmem_miss_cnt,
  output logic [31:0]            dmem_wb_cnt
`endif
);

  localparam logic [DMEM_ADDR_W-1:0] WIN_MASK = (32'd1 << DEPTH_LOG2) - 32'd1;
  localparam logic [DEPTH_LOG2-1:0]  CNT_LAST = '1;
  localparam logic [DEPTH_LOG2-1:0]  CNT_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  dmem_state_e              state_q, state_d;
  logic [DEPTH_LOG2-1:0]    cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     dirty_q, dirty_d;
  logic [DMEM_ADDR_W-1:0]   base_q, base_d;
  logic [DMEM_ADDR_W-1:0]   high_q, high_d;
  logic [DMEM_ADDR_W-1:0]   new_base_q, new_base_d;
  logic                     ext_req_q, ext_req_d;
  logic                     ext_we_q, ext_we_d;
  logic [DMEM_ADDR_W-1:0]   ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0]        ext_wdata_q, ext_wdata_d;

  logic                     hit, miss, store_hit, ack_v;
  logic [DEPTH_LOG2-1:0]    off, cnt_inc;
  logic [DMEM_ADDR_W-1:0]   cnt_inc_ext;
  logic                     ram_we;
  logic [DEPTH_LOG2-1:0]    ram_waddr, ram_raddr;
  logic [DATA_W-1:0]        ram_wdata, ram_rdata;

  assign off         = DMEM_Addr[DEPTH_LOG2-1:0];
  assign hit         = valid_q && (DMEM_Addr >= base_q) && (DMEM_Addr <= high_q);
  // Own address compare gates the lagging DMEM_no_hit so a just-committed window is not refilled again
  assign miss        = (state_q == ST_IDLE) && DMEM_no_hit && !hit;
  assign store_hit   = (state_q == ST_IDLE) && DMEM_WE && hit;
  assign ack_v       = ext_ack && ext_req_q;
  assign cnt_inc     = cnt_q + CNT_ONE;
  assign cnt_inc_ext = {{(DMEM_ADDR_W-DEPTH_LOG2){1'b0}}, cnt_inc};

  // The single read port serves loads in IDLE and prefetches the next writeback word otherwise
  assign ram_raddr = (state_q == ST_WB) ? cnt_inc : (miss ? '0 : off);

  dmem_window_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    base_d      = base_q;
    high_d      = high_q;
    new_base_d  = new_base_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ram_we      = 1'b0;
    ram_waddr   = off;
    ram_wdata   = DMEM_Data;

    unique case (state_q)
      ST_IDLE: begin
        if (store_hit) begin
          ram_we  = 1'b1;
          dirty_d = 1'b1;
        end else if (miss) begin
          new_base_d = win_align(DMEM_Addr, DEPTH_LOG2);
          cnt_d      = '0;
          ext_req_d  = 1'b1;
          if (valid_q && dirty_q) begin
            state_d     = ST_WB;
            ext_we_d    = 1'b1;
            ext_addr_d  = base_q;
            ext_wdata_d = ram_rdata;
          end else begin
            state_d    = ST_FILL;
            ext_we_d   = 1'b0;
            ext_addr_d = win_align(DMEM_Addr, DEPTH_LOG2);
          end
        end
      end

      ST_WB: begin
        if (ack_v) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            state_d    = ST_FILL;
            ext_we_d   = 1'b0;
            ext_addr_d = new_base_q;
          end else begin
            cnt_d       = cnt_inc;
            ext_addr_d  = base_q + cnt_inc_ext;
            ext_wdata_d = ram_rdata;
          end
        end
      end

      ST_FILL: begin
        if (ack_v) begin
          ram_we    = 1'b1;
          ram_waddr = cnt_q;
          ram_wdata = ext_rdata;
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            state_d   = ST_COMMIT;
            ext_req_d = 1'b0;
          end else begin
            cnt_d      = cnt_inc;
            ext_addr_d = new_base_q + cnt_inc_ext;
          end
        end
      end

      ST_COMMIT: begin
        base_d    = new_base_q;
        high_d    = new_base_q | WIN_MASK;
        valid_d   = 1'b1;
        dirty_d   = 1'b0;
        ext_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      dirty_q     <= 1'b0;
      base_q      <= DMEM_BASE_INVALID;
      high_q      <= DMEM_HIGH_INVALID;
      new_base_q  <= '0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      base_q      <= base_d;
      high_q      <= high_d;
      new_base_q  <= new_base_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
    end
  end

  assign DMEM_DATA_WB_w = ram_rdata;
  assign DMEM_Base_Addr = base_q;
  assign DMEM_High_Addr = high_q;
  assign dmem_busy      = (state_q != ST_IDLE);
  assign ext_req        = ext_req_q;
  assign ext_we         = ext_we_q;
  assign ext_addr       = ext_addr_q;
  assign ext_wdata      = ext_wdata_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if (miss && valid_q && dirty_q && (wb_cnt_q != 32'hFFFF_FFFF)) begin
      wb_cnt_d = wb_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign dmem_miss_cnt = miss_cnt_q;
  assign dmem_wb_cnt   = wb_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_dmem_window.sv
`default_nettype none
// tb_cpu_dmem_window: directed + randomized bench; the reference is a flat
// word-addressed memory (CPU view + backing store), not a window model.
module tb_cpu_dmem_window;

  localparam int BUDGET = 400;

  logic        clk, rst;
  logic        DMEM_WE, DMEM_no_hit;
  logic [31:0] DMEM_Addr, DMEM_Data, DMEM_DATA_WB_w, DMEM_Base_Addr, DMEM_High_Addr;
  logic        dmem_busy, ext_req, ext_we, ext_ack;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] dmem_miss_cnt, dmem_wb_cnt;
`endif

  int n_cmp, n_fail;
  int ack_gap, wcnt, acked;
  bit spur_en, have_prev;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;

  logic [31:0] xmem     [logic [31:0]];
  logic [31:0] cpu_view [logic [31:0]];
  logic [31:0] rd_q[$], wa_q[$], wd_q[$];

  logic [31:0] base_m;
  bit          valid_m, dirty_m;
  int          exp_miss, exp_wb;

  cpu_dmem_window #(.DEPTH_LOG2(4), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .DMEM_WE        (DMEM_WE),
    .DMEM_Addr      (DMEM_Addr),
    .DMEM_Data      (DMEM_Data),
    .DMEM_no_hit    (DMEM_no_hit),
    .DMEM_DATA_WB_w (DMEM_DATA_WB_w),
    .DMEM_Base_Addr (DMEM_Base_Addr),
    .DMEM_High_Addr (DMEM_High_Addr),
    .dmem_busy      (dmem_busy),
    .ext_req        (ext_req),
    .ext_we         (ext_we),
    .ext_addr       (ext_addr),
    .ext_wdata      (ext_wdata),
    .ext_rdata      (ext_rdata),
    .ext_ack        (ext_ack)
`ifdef DMEM_PERF_CNT_EN
    ,
    .dmem_miss_cnt  (dmem_miss_cnt),
    .dmem_wb_cnt    (dmem_wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] xread(input logic [31:0] a);
    if (xmem.exists(a)) return xmem[a];
    return a + 32'h100;
  endfunction

  function automatic logic [31:0] view(input logic [31:0] a);
    if (cpu_view.exists(a)) return cpu_view[a];
    return xread(a);
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return valid_m && ((a & ~32'hF) == base_m);
  endfunction

  always @(posedge clk) if (rst && ext_req && ext_ack) acked++;

  // External memory responder: acks every (ack_gap+1)-th requested cycle
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      ext_ack = 1'b0; ext_rdata = '0; wcnt = 0; have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        n_cmp++;
        if (ext_req !== 1'b1 || ext_addr !== prev_addr || ext_we !== prev_we || ext_wdata !== prev_wdata) begin
          n_fail++;
          $display("FAIL hold_stable: got req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                   ext_req, ext_addr, ext_we, ext_wdata, prev_addr, prev_we, prev_wdata);
        end
      end
      have_prev = 1'b0;
      if (ext_req) begin
        if (wcnt >= ack_gap) begin
          ext_ack = 1'b1; wcnt = 0;
          if (ext_we) begin
            n_cmp++;
            if (ext_wdata !== view(ext_addr)) begin
              n_fail++;
              $display("FAIL wb_data @%h: got %h, required %h", ext_addr, ext_wdata, view(ext_addr));
            end
            wa_q.push_back(ext_addr); wd_q.push_back(ext_wdata);
            xmem[ext_addr] = ext_wdata;
          end else begin
            ext_rdata = xread(ext_addr);
            rd_q.push_back(ext_addr);
          end
        end else begin
          ext_ack = 1'b0; wcnt++;
          have_prev = 1'b1; prev_addr = ext_addr; prev_we = ext_we; prev_wdata = ext_wdata;
        end
      end else begin
        ext_ack = spur_en ? 1'($urandom_range(1, 0)) : 1'b0;
        ext_rdata = $urandom; wcnt = 0;
      end
    end
  end

  // Drive a missing access and wait (bounded) until the reported window covers it
  task automatic refill(input logic [31:0] a, input bit keep, output int cyc);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    if (valid_m && dirty_m) exp_wb++;
    exp_miss++;
    DMEM_Addr = a; DMEM_WE = 1'b0; DMEM_no_hit = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!(DMEM_Base_Addr <= a && a <= DMEM_High_Addr) && cyc < BUDGET);
    if (!keep) DMEM_no_hit = 1'b0;
    base_m = a & ~32'hF; valid_m = 1'b1; dirty_m = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    DMEM_Addr = a; DMEM_Data = d; DMEM_WE = 1'b1; DMEM_no_hit = 1'b0;
    @(negedge clk);
    DMEM_WE = 1'b0;
    cpu_view[a] = d; dirty_m = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; DMEM_WE = 0; DMEM_no_hit = 0; DMEM_Addr = 0; DMEM_Data = 0;
    ack_gap = 0; spur_en = 0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (DMEM_Base_Addr !== 32'hFFFF_FFFF || DMEM_High_Addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_bounds: got %h/%h, required ffffffff/00000000", DMEM_Base_Addr, DMEM_High_Addr);
    end
    n_cmp++;
    if ({ext_req, ext_we, dmem_busy} !== 3'b000 || ext_addr !== 0 || ext_wdata !== 0) begin
      n_fail++; $display("FAIL reset_bus: got req=%b we=%b busy=%b addr=%h wdata=%h, required all 0",
                         ext_req, ext_we, dmem_busy, ext_addr, ext_wdata);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dmem_busy !== 1'b0 || ext_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b req=%b, required 0/0", dmem_busy, ext_req);
    end
  endtask

  task automatic test_clean_fill();
    int cyc;
    ack_gap = 0;
    refill(32'h0, 1'b0, cyc);
    n_cmp++;
    if (cyc != 18) begin n_fail++; $display("FAIL clean_latency: got %0d, required 18", cyc); end
    n_cmp++;
    if (rd_q.size() != 16 || wa_q.size() != 0) begin
      n_fail++; $display("FAIL clean_counts: got reads=%0d writes=%0d, required 16/0", rd_q.size(), wa_q.size());
    end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      n_cmp++;
      if (rd_q[i] !== 32'(i)) begin n_fail++; $display("FAIL fill_addr[%0d]: got %h, required %h", i, rd_q[i], i); end
    end
    n_cmp++;
    if (DMEM_Base_Addr !== 32'h0 || DMEM_High_Addr !== 32'hF) begin
      n_fail++; $display("FAIL clean_bounds: got %h/%h, required 0/f", DMEM_Base_Addr, DMEM_High_Addr);
    end
    DMEM_Addr = 32'h5; #1;
    n_cmp++;
    if (DMEM_DATA_WB_w !== 32'h105) begin n_fail++; $display("FAIL load5: got %h, required 00000105", DMEM_DATA_WB_w); end
    @(negedge clk);
  endtask

  task automatic test_dirty_wb();
    int cyc;
    do_store(32'h3, 32'hDEAD_BEEF);
    DMEM_Addr = 32'h3; #1;
    n_cmp++;
    if (DMEM_DATA_WB_w !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_load: got %h, required deadbeef", DMEM_DATA_WB_w); end
    @(negedge clk);
    refill(32'h40, 1'b1, cyc);
    n_cmp++;
    if (cyc != 34) begin n_fail++; $display("FAIL dirty_latency: got %0d, required 34", cyc); end
    n_cmp++;
    if (wa_q.size() != 16 || rd_q.size() != 16) begin
      n_fail++; $display("FAIL dirty_counts: got writes=%0d reads=%0d, required 16/16", wa_q.size(), rd_q.size());
    end
    for (int i = 0; i < 16 && i < wa_q.size() && i < rd_q.size(); i++) begin
      n_cmp++;
      if (wa_q[i] !== 32'(i) || wd_q[i] !== ((i == 3) ? 32'hDEAD_BEEF : 32'h100 + 32'(i)) || rd_q[i] !== 32'h40 + 32'(i)) begin
        n_fail++; $display("FAIL wb_fill[%0d]: got wa=%h wd=%h ra=%h", i, wa_q[i], wd_q[i], rd_q[i]);
      end
    end
    n_cmp++;
    if (DMEM_Base_Addr !== 32'h40 || DMEM_High_Addr !== 32'h4F) begin
      n_fail++; $display("FAIL dirty_bounds: got %h/%h, required 40/4f", DMEM_Base_Addr, DMEM_High_Addr);
    end
  endtask

  task automatic test_no_double_refill();
    DMEM_Addr = 32'h45;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (ext_req !== 1'b0 || dmem_busy !== 1'b0) begin
        n_fail++; $display("FAIL second_refill: got req=%b busy=%b, required 0/0", ext_req, dmem_busy);
      end
    end
    DMEM_no_hit = 1'b0;
    n_cmp++;
    if (rd_q.size() != 16) begin n_fail++; $display("FAIL extra_reads: got %0d, required 16", rd_q.size()); end
  endtask

  task automatic test_slow_ack();
    int cyc;
    ack_gap = 2;
    refill(32'h80, 1'b0, cyc);
    n_cmp++;
    if (cyc >= BUDGET || rd_q.size() != 16 || wa_q.size() != 0) begin
      n_fail++; $display("FAIL slow_fill: got cyc=%0d reads=%0d writes=%0d, required <%0d/16/0", cyc, rd_q.size(), wa_q.size(), BUDGET);
    end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      n_cmp++;
      if (rd_q[i] !== 32'h80 + 32'(i)) begin n_fail++; $display("FAIL slow_addr[%0d]: got %h, required %h", i, rd_q[i], 32'h80 + 32'(i)); end
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'h80 + 32'($urandom_range(15, 0));
      DMEM_Addr = a; #1;
      n_cmp++;
      if (DMEM_DATA_WB_w !== view(a)) begin n_fail++; $display("FAIL slow_load @%h: got %h, required %h", a, DMEM_DATA_WB_w, view(a)); end
      @(negedge clk);
    end
    ack_gap = 0;
  endtask

  task automatic test_reset_mid_fill();
    int start, cyc, n;
    ack_gap = 0;
    DMEM_Addr = 32'h200; DMEM_no_hit = 1'b1;
    start = acked; n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while ((acked - start) < 7 && n < BUDGET);
    n_cmp++;
    if (acked - start != 7) begin n_fail++; $display("FAIL mid_fill_acks: got %0d, required 7", acked - start); end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (ext_req !== 0 || ext_we !== 0 || ext_addr !== 0 || ext_wdata !== 0 || dmem_busy !== 0 ||
        DMEM_Base_Addr !== 32'hFFFF_FFFF || DMEM_High_Addr !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got req=%b we=%b addr=%h wdata=%h busy=%b base=%h high=%h",
                         ext_req, ext_we, ext_addr, ext_wdata, dmem_busy, DMEM_Base_Addr, DMEM_High_Addr);
    end
    @(negedge clk);
    DMEM_no_hit = 1'b0;
    rst = 1'b1;
    cpu_view = xmem; valid_m = 1'b0; dirty_m = 1'b0; exp_miss = 0; exp_wb = 0;
    @(negedge clk);
    refill(32'h0, 1'b0, cyc);
    n_cmp++;
    if (cyc != 18 || rd_q.size() != 16) begin
      n_fail++; $display("FAIL refill_after_reset: got cyc=%0d reads=%0d, required 18/16", cyc, rd_q.size());
    end
    n_cmp++;
    if (rd_q.size() == 0 || rd_q[0] !== 32'h0) begin n_fail++; $display("FAIL restart_word0: first read not at 00000000"); end
    DMEM_Addr = 32'h9; #1;
    n_cmp++;
    if (DMEM_DATA_WB_w !== view(32'h9)) begin n_fail++; $display("FAIL load9: got %h, required %h", DMEM_DATA_WB_w, view(32'h9)); end
    @(negedge clk);
  endtask

  task automatic test_top_window();
    int cyc;
    refill(32'hFFFF_FFF7, 1'b0, cyc);
    n_cmp++;
    if (DMEM_Base_Addr !== 32'hFFFF_FFF0 || DMEM_High_Addr !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL top_bounds: got %h/%h, required fffffff0/ffffffff", DMEM_Base_Addr, DMEM_High_Addr);
    end
    n_cmp++;
    if (rd_q.size() != 16 || rd_q[15] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL top_reads: count %0d", rd_q.size()); end
    DMEM_Addr = 32'hFFFF_FFF7; #1;
    n_cmp++;
    if (DMEM_DATA_WB_w !== view(32'hFFFF_FFF7)) begin
      n_fail++; $display("FAIL top_load: got %h, required %h", DMEM_DATA_WB_w, view(32'hFFFF_FFF7));
    end
    @(negedge clk);
`ifdef DMEM_PERF_CNT_EN
    n_cmp++;
    if (dmem_miss_cnt !== 32'(exp_miss) || dmem_wb_cnt !== 32'(exp_wb)) begin
      n_fail++; $display("FAIL perf_cnt: got miss=%0d wb=%0d, required %0d/%0d", dmem_miss_cnt, dmem_wb_cnt, exp_miss, exp_wb);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] bases [4];
    bases[0] = 32'h0; bases[1] = 32'h40; bases[2] = 32'h1230; bases[3] = 32'hFFFF_FFF0;
    spur_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int cyc, exp_wr;
      a = bases[$urandom_range(3, 0)] + 32'($urandom_range(15, 0));
      if (in_win(a)) begin
        if ($urandom_range(1, 0) == 1) begin
          do_store(a, $urandom);
        end else begin
          DMEM_Addr = a; DMEM_no_hit = 1'b0; #1;
          n_cmp++;
          if (DMEM_DATA_WB_w !== view(a)) begin n_fail++; $display("FAIL rand_load @%h: got %h, required %h", a, DMEM_DATA_WB_w, view(a)); end
          @(negedge clk);
        end
      end else begin
        ack_gap = $urandom_range(2, 0);
        exp_wr = (valid_m && dirty_m) ? 16 : 0;
        refill(a, 1'b0, cyc);
        n_cmp++;
        if (cyc >= BUDGET || wa_q.size() != exp_wr || rd_q.size() != 16 || rd_q[0] !== (a & ~32'hF) ||
            DMEM_Base_Addr !== (a & ~32'hF) || DMEM_High_Addr !== (a | 32'hF)) begin
          n_fail++; $display("FAIL rand_refill @%h: got cyc=%0d writes=%0d reads=%0d base=%h high=%h, required writes=%0d",
                             a, cyc, wa_q.size(), rd_q.size(), DMEM_Base_Addr, DMEM_High_Addr, exp_wr);
        end
      end
    end
    spur_en = 1'b0;
    ack_gap = 0;
    @(negedge clk);
`ifdef DMEM_PERF_CNT_EN
    n_cmp++;
    if (dmem_miss_cnt !== 32'(exp_miss) || dmem_wb_cnt !== 32'(exp_wb)) begin
      n_fail++; $display("FAIL rand_perf_cnt: got miss=%0d wb=%0d, required %0d/%0d", dmem_miss_cnt, dmem_wb_cnt, exp_miss, exp_wb);
    end
`endif
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; acked = 0;
    valid_m = 1'b0; dirty_m = 1'b0; base_m = '0; exp_miss = 0; exp_wb = 0;
    test_reset();
    test_clean_fill();
    test_dirty_wb();
    test_no_double_refill();
    test_slow_ack();
    test_reset_mid_fill();
    test_top_window();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
